// File: rtl/bc_score_display_if.sv
// Result handshake between the bulls-and-cows game core and the score display.
// The game core drives the master side and the display drives the slave side.
interface bc_score_display_if;
   logic       res_valid;
   logic       res_ready;
   logic [2:0] res_bulls;
   logic [2:0] res_cows;
   logic [3:0] res_attempt;

   modport master (
      output res_valid,
      output res_bulls,
      output res_cows,
      output res_attempt,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_bulls,
      input  res_cows,
      input  res_attempt,
      output res_ready
   );
endinterface

// File: rtl/bc_score_display.sv
// Bulls-and-cows score display.
// Each accepted result is shown as a loop of timed screens on a single
// 7-segment digit: bulls, then cows (dp lit), and, when BC_DISP_ATTEMPT_EN is
// defined, the attempt number (dp blinking). A win blinks a digit until the
// next clear. A malformed score shows a steady "E".
// Build option BC_DISP_ATTEMPT_EN: adds the attempt screen to the loop, and
// the win screen blinks the attempt number instead of "4".
//
// state  | meaning
// IDLE   | no result held, shows "-"
// SHOW_B | bulls digit, dp off
// SHOW_C | cows digit, dp on
// SHOW_N | attempt digit, dp toggles every half hold (option only)
// WIN    | 4 bulls: digit / blank blink, new results refused
// ERR    | malformed score, steady "E"
module bc_score_display #(
   parameter int HOLD_CYCLES = 10_000_000,
   parameter int CNT_W       = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   bc_score_display_if.slave     res,
   output logic [7:0]            segment_out,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, SHOW_B, SHOW_C, SHOW_N, WIN, ERR} state_t;

   localparam logic [CNT_W-1:0] TIMER_TC = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic             blank;
   logic [2:0]       bulls_q;
   logic [2:0]       cows_q;
   logic             accept;
   logic             dp_next;
   logic [3:0]       digit_acc;
   logic [3:0]       digit_cur;

   function automatic logic [7:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 8'h3F;
         4'h1: glyph = 8'h06;
         4'h2: glyph = 8'h5B;
         4'h3: glyph = 8'h4F;
         4'h4: glyph = 8'h66;
         4'h5: glyph = 8'h6D;
         4'h6: glyph = 8'h7D;
         4'h7: glyph = 8'h07;
         4'h8: glyph = 8'h7F;
         4'h9: glyph = 8'h6F;
         4'hA: glyph = 8'h77;
         4'hB: glyph = 8'h7C;
         4'hC: glyph = 8'h39;
         4'hD: glyph = 8'h5E;
         4'hE: glyph = 8'h79;
         default: glyph = 8'h71;
      endcase
   endfunction

   // Segment pattern for a screen; n is the attempt/win digit, dp_n the SHOW_N dp.
   function automatic logic [7:0] screen(input state_t st, input logic blank_n,
                                         input logic dp_n, input logic [2:0] b,
                                         input logic [2:0] c, input logic [3:0] n);
      case (st)
         SHOW_B:  screen = glyph({1'b0, b});
         SHOW_C:  screen = glyph({1'b0, c}) | 8'h80;
         SHOW_N:  screen = glyph(n) | {dp_n, 7'b0};
         WIN:     screen = blank_n ? 8'h00 : glyph(n);
         ERR:     screen = 8'h79;
         default: screen = 8'h40;
      endcase
   endfunction

   // Sum is formed at 4 bits so 4+4 cannot alias to a legal value.
   function automatic state_t decode(input logic [2:0] b, input logic [2:0] c);
      logic [3:0] sum;
      sum = {1'b0, b} + {1'b0, c};
      if (b > 3'd4 || c > 3'd4 || sum > 4'd4) decode = ERR;
      else if (b == 3'd4)                     decode = WIN;
      else                                    decode = SHOW_B;
   endfunction

   function automatic state_t next_screen(input state_t st);
      case (st)
         SHOW_B:  next_screen = SHOW_C;
`ifdef BC_DISP_ATTEMPT_EN
         SHOW_C:  next_screen = SHOW_N;
`else
         SHOW_C:  next_screen = SHOW_B;
`endif
         SHOW_N:  next_screen = SHOW_B;
         default: next_screen = st;
      endcase
   endfunction

   assign res.res_ready = ~clear & (state != WIN);
   assign accept        = res.res_valid & res.res_ready;

`ifdef BC_DISP_ATTEMPT_EN
   localparam logic [CNT_W-1:0] TIMER_HALF = CNT_W'(HOLD_CYCLES / 2);
   logic [3:0] attempt_q;

   // dp of the attempt screen is lit for the first half of each hold.
   assign dp_next   = (timer + 1'b1) < TIMER_HALF;
   assign digit_acc = res.res_attempt;
   assign digit_cur = attempt_q;

   // Attempt number is only captured on accept.
   always_ff @(posedge clk) begin
      if (!rst_n)      attempt_q <= '0;
      else if (accept) attempt_q <= res.res_attempt;
   end
`else
   assign dp_next   = 1'b0;
   assign digit_acc = 4'd4;
   assign digit_cur = 4'd4;
`endif

   // Screen sequencer: clear beats accept, accept beats the hold timer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         segment_out <= 8'h40;
         busy        <= 1'b0;
         timer       <= '0;
         blank       <= 1'b0;
         bulls_q     <= '0;
         cows_q      <= '0;
      end else if (clear) begin
         state       <= IDLE;
         segment_out <= 8'h40;
         busy        <= 1'b0;
         timer       <= '0;
         blank       <= 1'b0;
      end else if (accept) begin
         bulls_q     <= res.res_bulls;
         cows_q      <= res.res_cows;
         state       <= decode(res.res_bulls, res.res_cows);
         segment_out <= screen(decode(res.res_bulls, res.res_cows), 1'b0, 1'b1,
                               res.res_bulls, res.res_cows, digit_acc);
         busy        <= 1'b1;
         timer       <= '0;
         blank       <= 1'b0;
      end else if (state inside {SHOW_B, SHOW_C, SHOW_N, WIN}) begin
         if (timer == TIMER_TC) begin
            timer <= '0;
            if (state == WIN) begin
               blank       <= ~blank;
               segment_out <= screen(WIN, ~blank, 1'b1, bulls_q, cows_q, digit_cur);
            end else begin
               state       <= next_screen(state);
               segment_out <= screen(next_screen(state), 1'b0, 1'b1,
                                     bulls_q, cows_q, digit_cur);
            end
         end else begin
            timer       <= timer + 1'b1;
            segment_out <= screen(state, blank, dp_next, bulls_q, cows_q, digit_cur);
         end
      end
   end

endmodule

// File: tb/tb_bc_score_display.sv
// Scoreboard bench for bc_score_display with a 4-cycle hold.
// Stimulus queues the expected display for specific cycle numbers; the monitor
// compares segment_out/busy/res_ready on each falling edge.
module tb_bc_score_display;
   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic [7:0] segment_out;
   logic       busy;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   typedef struct {
      int         cyc;
      logic [7:0] seg;
      logic       busy;
      logic       rdy;
   } exp_t;
   exp_t exp_q[$];

   bc_score_display_if rif ();

   bc_score_display #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .res         (rif.slave),
      .segment_out (segment_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missed_check cycle %0d expected seg %h", e.cyc, e.seg);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         if (segment_out !== e.seg || busy !== e.busy || rif.res_ready !== e.rdy) begin
            n_fail++;
            $display("FAIL display cycle %0d: got seg=%h busy=%b ready=%b, expected seg=%h busy=%b ready=%b",
                     cyc, segment_out, busy, rif.res_ready, e.seg, e.busy, e.rdy);
         end
      end
   end

   task automatic push(input int c, input logic [7:0] s, input logic b, input logic r);
      exp_t e;
      e.cyc = c; e.seg = s; e.busy = b; e.rdy = r;
      exp_q.push_back(e);
   endtask

   task automatic seq(input int c, input int n, input logic [7:0] s,
                      input logic b, input logic r);
      for (int i = 0; i < n; i++) push(c + i, s, b, r);
   endtask

   // Offer a result now; the accepting edge makes it visible at cycle base.
   task automatic offer(input logic [2:0] b, input logic [2:0] c,
                        input logic [3:0] a, output int base);
      rif.res_valid   = 1'b1;
      rif.res_bulls   = b;
      rif.res_cows    = c;
      rif.res_attempt = a;
      base = cyc + 1;
   endtask

   task automatic step();
      @(posedge clk); #1;
      rif.res_valid = 1'b0;
      clear         = 1'b0;
      rst_n         = 1'b1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int b1, b2, b3, b4, b5, b6;
      logic [7:0] win_g;
      rst_n           = 1'b0;
      clear           = 1'b0;
      rif.res_valid   = 1'b0;
      rif.res_bulls   = '0;
      rif.res_cows    = '0;
      rif.res_attempt = '0;

      // reset
      repeat (2) @(posedge clk);
      #1;
      push(cyc, 8'h40, 1'b0, 1'b1);
      push(cyc + 1, 8'h40, 1'b0, 1'b1);
      rst_n = 1'b1;
      goto(4);

      // b=1 c=2: 1 / 2. / 1 loop
      offer(3'd1, 3'd2, 4'd0, b1);
      seq(b1,     4, 8'h06, 1'b1, 1'b1);
      seq(b1 + 4, 4, 8'hDB, 1'b1, 1'b1);
      seq(b1 + 8, 4, 8'h06, 1'b1, 1'b1);
      step();
      goto(b1 + 11);

      // new result during SHOW_C restarts on a full bulls hold
      seq(b1 + 12, 2, 8'hDB, 1'b1, 1'b1);
      goto(b1 + 13);
      offer(3'd2, 3'd1, 4'd0, b2);
      seq(b2,     4, 8'h5B, 1'b1, 1'b1);
      seq(b2 + 4, 4, 8'h86, 1'b1, 1'b1);
      step();
      goto(b2 + 7);

      // malformed score, then recovery by a new accept
      offer(3'd3, 3'd2, 4'd0, b3);
      seq(b3, 6, 8'h79, 1'b1, 1'b1);
      step();
      goto(b3 + 5);
      offer(3'd0, 3'd1, 4'd0, b4);
      seq(b4,     4, 8'h3F, 1'b1, 1'b1);
      push(b4 + 4,   8'h86, 1'b1, 1'b1);
      push(b4 + 5,   8'h86, 1'b1, 1'b0);
      step();
      goto(b4 + 5);

      // clear together with a winning result: dropped, back to "-"
      clear = 1'b1;
      offer(3'd4, 3'd0, 4'd9, b5);
      seq(b4 + 6, 3, 8'h40, 1'b0, 1'b1);
      step();
      goto(b4 + 8);

      // win blink, refused results, cleared
`ifdef BC_DISP_ATTEMPT_EN
      win_g = 8'h6F;
`else
      win_g = 8'h66;
`endif
      offer(3'd4, 3'd0, 4'd9, b5);
      seq(b5,     4, win_g, 1'b1, 1'b0);
      seq(b5 + 4, 4, 8'h00, 1'b1, 1'b0);
      seq(b5 + 8, 4, win_g, 1'b1, 1'b0);
      step();
      goto(b5 + 11);
      clear = 1'b1;
      push(b5 + 12, 8'h40, 1'b0, 1'b1);
      push(b5 + 13, 8'h40, 1'b0, 1'b1);
      step();
      goto(b5 + 13);

      // b=0 c=0 attempt A
      offer(3'd0, 3'd0, 4'hA, b6);
      seq(b6,     4, 8'h3F, 1'b1, 1'b1);
      seq(b6 + 4, 4, 8'hBF, 1'b1, 1'b1);
`ifdef BC_DISP_ATTEMPT_EN
      seq(b6 + 8,  2, 8'hF7, 1'b1, 1'b1);
      seq(b6 + 10, 2, 8'h77, 1'b1, 1'b1);
      seq(b6 + 12, 2, 8'h3F, 1'b1, 1'b1);
`else
      seq(b6 + 8,  4, 8'h3F, 1'b1, 1'b1);
      seq(b6 + 12, 2, 8'hBF, 1'b1, 1'b1);
`endif
      step();
      goto(b6 + 13);

      // reset mid-screen
      rst_n = 1'b0;
      push(b6 + 14, 8'h40, 1'b0, 1'b1);
      push(b6 + 15, 8'h40, 1'b0, 1'b1);
      step();
      goto(b6 + 16);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
